cpu_core_hs: RTL
================

// Module: cpu_core_hs
// PURPOSE
//  Parametrised multi-cycle 8-bit-ISA CPU core; next generation of the tri-state-bus CPU.
//  Single clock, no derived phase clocks; point-to-point memory port with req/ready handshake.
//  Adds Z/C flags, conditional jumps on both flags, and width-generic datapath.
//  Sits between top-level memory/IO and the program image; ALU is a sub-module.
// PARAMETERS
//  DATA_W      8   datapath/register width (>=8); opcode = low 8 bits of fetched word
//  ADDR_W      8   memory address width (<=DATA_W); immediates truncated to ADDR_W for addresses
//  RESET_PC    0   PC value loaded on reset
//  STACK_DEPTH 4   return-stack entries (used only with CPU_CALL_STACK_EN)
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset_n    in   1       synchronous, active-low reset
//  mem_req    out  1       memory request; held with addr/we/wdata until mem_ready
//  mem_we     out  1       1 = write, 0 = read
//  mem_addr   out  ADDR_W  access address
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid in the cycle mem_ready=1
//  mem_ready  in   1       completes the access in the cycle sampled high with mem_req
//  out_valid  out  1       one-cycle pulse: out_data carries R0 (OUT instr)
//  out_data   out  DATA_W  R0 value at OUT
//  halted     out  1       core in HALT state
//  fault      out  1       sticky: illegal opcode or stack over/underflow
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): PC=RESET_PC, R0..R6=0, Z=C=0, state=FETCH, all outputs 0.
//  Reset mid-access: mem_req drops next cycle regardless of mem_ready; access discarded.
//  ISA (op = word[7:0]); register field 111 = memory at address in following word:
//   00000000 NOP | 00000001 HLT | 00000010 OUT | 00010ccc Jcc imm | 00011ddd LDI ddd,imm
//   01dddsss MOV d<-s (d=s=111 illegal) | 10mmmsss ALU R0<-R0 op R[s] (s=111 illegal)
//   ccc: 000 always,001 Z,010 NZ,011 C,100 NC, others illegal. Any undefined op -> illegal.
//   mmm: ADD,SUB,AND,OR,XOR,NOT(R0),SHL(R0),SHR(R0); C=carry/not-borrow/shifted-out bit,
//   0 for logic ops; Z=(result==0). Only ALU ops write flags; all arithmetic mod 2^DATA_W.
//  FSM: FETCH -> DECODE -> {EXEC | IMM -> [MEM] -> EXEC} -> FETCH; HLT/illegal -> HALT.
//   FETCH: read PC; on ready IR<=rdata, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0).
//   IMM: read PC into T, PC+1. MEM: read/write at T[ADDR_W-1:0]. EXEC: writeback/jump/out.
//   Jcc taken: PC<=T; not taken: PC already past imm. Each memory state waits for ready.
//  Zero-wait latency: ALU/MOV-reg/OUT 3 cycles; LDI, Jcc 4; MOV with memory 5.
//  HALT: absorbing until reset; mem_req=0; halted=1. Illegal op also sets fault=1.
// CONFIGURATION
//  CPU_CALL_STACK_EN defined: 00100000 CALL imm (push PC after imm, PC<=imm),
//   00100001 RET (PC<=pop); internal LIFO of STACK_DEPTH; push when full or pop when
//   empty -> HALT, fault=1, stack unchanged. CALL 4 cycles, RET 3 cycles.
//  Not defined: both opcodes illegal (HALT + fault); no stack storage synthesised.
// STRUCTURE
//  Shared header cpu_core_defs.vh: state encodings, opcode class/field constants,
//   condition codes, ALU mode codes; shared with assembler tests and the bench.
//  Sub-module cpu_alu_w #(DATA_W): combinational op/flag generation, mode from IR[5:3].
//  Core holds FSM, PC, IR, T, register file, flags, optional return stack.
// TESTING
//  Reset: hold reset_n=0 3 cycles mid-fetch -> mem_req=0 next cycle, PC=RESET_PC, outputs 0.
//  LDI R0,5; LDI R1,3; ADD; OUT; HLT -> out_data=8 once, Z=0,C=0, halted=1, fault=0.
//  DATA_W=8: LDI R0,0xFF; LDI R1,1; ADD; JZ 0x20 -> R0=0, Z=1, C=1, PC=0x20.
//  Random 0-3 cycle mem_ready stalls on MOV R2,[0x40]; MOV [0x41],R2 -> mem[0x41]=mem[0x40], req held stable.
//  PC wrap: HLT-free NOP at addr 0xFF, ADDR_W=8 -> next fetch addr 0x00.
//  CPU_CALL_STACK_EN, STACK_DEPTH=2: CALL,CALL return ok; third nested CALL -> halted=1, fault=1.

Source files
------------

// File: rtl/cpu_core_hs_pkg.sv
// cpu_core_hs_pkg: shared FSM states, ALU modes, opcode constants and opcode classifier
package cpu_core_hs_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_IMM, S_MEM, S_EXEC, S_HALT} state_e;
  typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_NOT, A_SHL, A_SHR} alu_mode_e;
  typedef enum logic [3:0] {C_NOP, C_HLT, C_OUT, C_JCC, C_LDI, C_MOV, C_ALU, C_CALL, C_RET, C_ILL} op_class_e;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HLT  = 8'h01;
  localparam logic [7:0] OP_OUT  = 8'h02;
  localparam logic [7:0] OP_CALL = 8'h20;
  localparam logic [7:0] OP_RET  = 8'h21;
  localparam logic [2:0] REG_MEM = 3'b111;
  localparam logic [2:0] CC_AL = 3'd0, CC_Z = 3'd1, CC_NZ = 3'd2, CC_C = 3'd3, CC_NC = 3'd4;
  function automatic op_class_e op_class(input logic [7:0] op, input logic stack_en);
    return op == OP_NOP ? C_NOP :
           op == OP_HLT ? C_HLT :
           op == OP_OUT ? C_OUT :
           (op[7:3] == 5'b00010 && op[2:0] <= CC_NC) ? C_JCC :
           (op[7:3] == 5'b00011 && op[2:0] != REG_MEM) ? C_LDI :
           (op[7:6] == 2'b01 && op[5:0] != 6'h3F) ? C_MOV :
           (op[7:6] == 2'b10 && op[2:0] != REG_MEM) ? C_ALU :
           (stack_en && op == OP_CALL) ? C_CALL :
           (stack_en && op == OP_RET) ? C_RET : C_ILL;
  endfunction
endpackage

// File: rtl/cpu_core_hs_alu.sv
// cpu_core_hs_alu: combinational ALU producing result plus carry and zero flags
//   i_a, i_b : operands (i_a is R0)   i_mode : operation
//   o_y      : result                 o_c, o_z : carry / zero flags
module cpu_core_hs_alu
  import cpu_core_hs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_mode_e         i_mode,
  output logic [DATA_W-1:0] o_y,
  output logic              o_c,
  output logic              o_z
);
  logic [DATA_W:0] w_sum, w_dif;
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};
  assign o_z = o_y == '0;
  always_comb begin
    o_y = '0;
    o_c = 1'b0;
    case (i_mode)
      A_ADD: {o_c, o_y} = w_sum;
      // carry after subtract is the inverted borrow
      A_SUB: {o_c, o_y} = {~w_dif[DATA_W], w_dif[DATA_W-1:0]};
      A_AND: o_y = i_a & i_b;
      A_OR:  o_y = i_a | i_b;
      A_XOR: o_y = i_a ^ i_b;
      A_NOT: o_y = ~i_a;
      A_SHL: {o_c, o_y} = {i_a, 1'b0};
      A_SHR: {o_y, o_c} = {1'b0, i_a};
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_core_hs.sv
// cpu_core_hs: multi-cycle 8-bit-ISA CPU core with req/ready memory port and Z/C flags
//   i_clk, i_reset_n (sync, active low)
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_rdata/i_mem_ready : memory handshake
//   o_out_valid/o_out_data : R0 pulse on OUT   o_halted, o_fault : status
//   Optional CALL/RET return stack enabled by defining CPU_CALL_STACK_EN.
module cpu_core_hs
  import cpu_core_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_halted,
  output logic              o_fault
);
`ifdef CPU_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  state_e            r_state, w_next;
  logic              r_run, r_z, r_c, r_fault;
  logic [ADDR_W-1:0] r_pc, w_ret_pc;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_t, w_rs, w_alu_y;
  logic [DATA_W-1:0] r_regs [0:7];
  logic              w_ack, w_take, w_need_imm, w_stk_err, w_alu_c, w_alu_z;
  op_class_e         w_cls;
  logic [2:0]        w_d, w_s;
  assign w_cls = op_class(r_ir, STACK_EN);
  assign w_d = r_ir[5:3];
  assign w_s = r_ir[2:0];
  assign w_rs = r_regs[w_s];
  // r_run holds the bus idle for one cycle after reset so mem_req is 0 while reset is applied
  assign o_mem_req = r_run && (r_state == S_FETCH || r_state == S_IMM || r_state == S_MEM);
  assign o_mem_we = r_state == S_MEM && w_d == REG_MEM;
  assign o_mem_addr = r_state == S_MEM ? r_t[ADDR_W-1:0] : r_pc;
  assign o_mem_wdata = o_mem_we ? w_rs : '0;
  assign w_ack = o_mem_req && i_mem_ready;
  assign o_out_valid = r_state == S_EXEC && w_cls == C_OUT;
  assign o_out_data = r_regs[0];
  assign o_halted = r_state == S_HALT;
  assign o_fault = r_fault;
  assign w_need_imm = w_cls == C_JCC || w_cls == C_LDI || w_cls == C_CALL ||
                      (w_cls == C_MOV && (w_d == REG_MEM || w_s == REG_MEM));
  assign w_take = w_s == CC_AL || (w_s == CC_Z && r_z) || (w_s == CC_NZ && !r_z) ||
                  (w_s == CC_C && r_c) || (w_s == CC_NC && !r_c);
  cpu_core_hs_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a(r_regs[0]), .i_b(w_rs), .i_mode(alu_mode_e'(w_d)),
    .o_y(w_alu_y), .o_c(w_alu_c), .o_z(w_alu_z)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = w_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (w_cls == C_HLT || w_cls == C_ILL || w_stk_err) ? S_HALT :
                         w_need_imm ? S_IMM : S_EXEC;
      S_IMM:    w_next = !w_ack ? S_IMM : w_cls == C_MOV ? S_MEM : S_EXEC;
      S_MEM:    w_next = w_ack ? S_EXEC : S_MEM;
      S_EXEC:   w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end
  always_ff @(posedge i_clk) r_state <= !i_reset_n ? S_FETCH : w_next;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_run <= 1'b0;
      r_pc <= ADDR_W'(RESET_PC);
      r_ir <= '0;
      r_t <= '0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_fault <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_state == S_FETCH && w_ack) begin
        r_ir <= i_mem_rdata[7:0];
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == S_IMM && w_ack) begin
        r_t <= i_mem_rdata;
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == S_MEM && w_ack && !o_mem_we) r_t <= i_mem_rdata;
      if (r_state == S_DECODE && (w_cls == C_ILL || w_stk_err)) r_fault <= 1'b1;
      if (r_state == S_EXEC) begin
        if (w_cls == C_LDI) r_regs[w_s] <= r_t;
        if (w_cls == C_MOV && w_d != REG_MEM) r_regs[w_d] <= w_s == REG_MEM ? r_t : w_rs;
        if (w_cls == C_ALU) begin
          r_regs[0] <= w_alu_y;
          r_z <= w_alu_z;
          r_c <= w_alu_c;
        end
        if ((w_cls == C_JCC && w_take) || w_cls == C_CALL) r_pc <= r_t[ADDR_W-1:0];
        if (w_cls == C_RET) r_pc <= w_ret_pc;
      end
    end
  end
`ifdef CPU_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IXW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] r_stack [0:STACK_DEPTH-1];
  logic [SPW-1:0]    r_sp, w_top;
  assign w_top = r_sp - 1'b1;
  assign w_ret_pc = r_stack[w_top[IXW-1:0]];
  // overflow/underflow is caught in DECODE so the stack is never modified by a faulting op
  assign w_stk_err = (w_cls == C_CALL && r_sp == SPW'(STACK_DEPTH)) || (w_cls == C_RET && r_sp == '0);
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_sp <= '0;
    else if (r_state == S_EXEC && w_cls == C_CALL) begin
      r_stack[r_sp[IXW-1:0]] <= r_pc;
      r_sp <= r_sp + 1'b1;
    end else if (r_state == S_EXEC && w_cls == C_RET) r_sp <= w_top;
  end
`else
  assign w_ret_pc = '0;
  assign w_stk_err = 1'b0;
`endif
endmodule
